// File: rtl/gomoku_move_ctrl.sv
// gomoku_move_ctrl: cursor control, move issue and turn sequencing for the gomoku board
module gomoku_move_ctrl #(
    parameter int BOARD_N = 7,
    parameter int COORD_W = 3,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_place,
    input  logic [1:0]         cell_val,
    input  logic [1:0]         game_state,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               go,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               color,
    output logic [CNT_W-1:0]   move_count,
    output logic               reject,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               draw
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, EVAL, OVER} state_t;

    localparam logic [COORD_W-1:0] MAX  = COORD_W'(BOARD_N - 1);
    localparam logic [COORD_W-1:0] MID  = COORD_W'(BOARD_N / 2);
    localparam logic [CNT_W-1:0]   FULL = CNT_W'(BOARD_N * BOARD_N);

    state_t             state, state_n;
    logic [COORD_W-1:0] cur_x_n, cur_y_n, x_n, y_n;
    logic [CNT_W-1:0]   count_n, count_inc;
    logic               go_n, color_n, reject_n, game_over_n, draw_n;
    logic [1:0]         winner_n;

    // next-state and next-output logic; go and reject default low so they pulse
    always_comb begin
        state_n     = state;
        cur_x_n     = cur_x;
        cur_y_n     = cur_y;
        x_n         = x;
        y_n         = y;
        go_n        = 1'b0;
        reject_n    = 1'b0;
        color_n     = color;
        count_n     = move_count;
        game_over_n = game_over;
        winner_n    = winner;
        draw_n      = draw;
        count_inc   = move_count + 1'b1;
        case (state)
            IDLE: begin
                if (btn_place) begin
                    state_n = CHECK;
                end else begin
                    cur_x_n = (btn_left && !btn_right && cur_x != '0) ? cur_x - 1'b1 :
                              (btn_right && !btn_left && cur_x != MAX) ? cur_x + 1'b1 : cur_x;
                    cur_y_n = (btn_up && !btn_down && cur_y != '0) ? cur_y - 1'b1 :
                              (btn_down && !btn_up && cur_y != MAX) ? cur_y + 1'b1 : cur_y;
                end
            end
            CHECK: begin
                if (cell_val != 2'd0) begin
                    reject_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    go_n    = 1'b1;
                    x_n     = cur_x;
                    y_n     = cur_y;
                    state_n = ISSUE;
                end
            end
            ISSUE: state_n = EVAL;
            EVAL: begin
                count_n = count_inc;
                if (game_state != 2'd0) begin
                    state_n     = OVER;
                    game_over_n = 1'b1;
                    winner_n    = game_state;
                end else if (count_inc == FULL) begin
                    state_n     = OVER;
                    game_over_n = 1'b1;
                    draw_n      = 1'b1;
                    winner_n    = 2'd0;
                end else begin
                    color_n = ~color;
                    state_n = IDLE;
                end
            end
            OVER:    state_n = OVER;
            default: state_n = IDLE;
        endcase
    end

    // register state and every output; reset overrides any in-flight move
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cur_x      <= MID;
            cur_y      <= MID;
            go         <= 1'b0;
            x          <= '0;
            y          <= '0;
            color      <= 1'b0;
            move_count <= '0;
            reject     <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'd0;
            draw       <= 1'b0;
        end else begin
            state      <= state_n;
            cur_x      <= cur_x_n;
            cur_y      <= cur_y_n;
            go         <= go_n;
            x          <= x_n;
            y          <= y_n;
            color      <= color_n;
            move_count <= count_n;
            reject     <= reject_n;
            game_over  <= game_over_n;
            winner     <= winner_n;
            draw       <= draw_n;
        end
    end
endmodule

// File: tb/tb_gomoku_move_ctrl.sv
// tb_gomoku_move_ctrl: directed bench with a move-level expectation model checked every cycle
module tb_gomoku_move_ctrl;
    logic       clk = 1'b0, resetn = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_place = 1'b0;
    logic [1:0] cell_val = 2'd0, game_state = 2'd0;
    logic [2:0] cur_x, cur_y, x, y;
    logic       go, color, reject, game_over, draw;
    logic [5:0] move_count;
    logic [1:0] winner;

    gomoku_move_ctrl dut (
        .clk(clk), .resetn(resetn), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_place(btn_place), .cell_val(cell_val), .game_state(game_state),
        .cur_x(cur_x), .cur_y(cur_y), .go(go), .x(x), .y(y), .color(color), .move_count(move_count),
        .reject(reject), .game_over(game_over), .winner(winner), .draw(draw)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;
    int e_cx, e_cy, e_go, e_x, e_y, e_color, e_cnt, e_rej, e_over, e_win, e_draw;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // every cycle, after outputs settle, compare all outputs with the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cur_x", 32'(cur_x), e_cx);
            check("cur_y", 32'(cur_y), e_cy);
            check("go", 32'(go), e_go);
            check("x", 32'(x), e_x);
            check("y", 32'(y), e_y);
            check("color", 32'(color), e_color);
            check("move_count", 32'(move_count), e_cnt);
            check("reject", 32'(reject), e_rej);
            check("game_over", 32'(game_over), e_over);
            check("winner", 32'(winner), e_win);
            check("draw", 32'(draw), e_draw);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_exp();
        e_cx = 3; e_cy = 3; e_go = 0; e_x = 0; e_y = 0; e_color = 0;
        e_cnt = 0; e_rej = 0; e_over = 0; e_win = 0; e_draw = 0;
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        btn_place = 1'b1;
        btn_left = 1'b1;
        repeat (n) begin
            cyc();
            reset_exp();
            chk_en = 1'b1;
        end
        resetn = 1'b1;
        btn_place = 1'b0;
        btn_left = 1'b0;
    endtask

    task automatic move(input bit u, input bit d, input bit l, input bit r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        cyc();
        if (e_over == 0) begin
            if (l && !r) e_cx = (e_cx > 0) ? e_cx - 1 : 0;
            if (r && !l) e_cx = (e_cx < 6) ? e_cx + 1 : 6;
            if (u && !d) e_cy = (e_cy > 0) ? e_cy - 1 : 0;
            if (d && !u) e_cy = (e_cy < 6) ? e_cy + 1 : 6;
        end
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    endtask

    // one place request; cursor buttons and a stray game_state are held around it and must be ignored
    task automatic place(input logic [1:0] cellv, input logic [1:0] gs);
        btn_place = 1; btn_left = 1; btn_up = 1; cell_val = cellv; game_state = 2'd1;
        cyc();
        btn_place = 0; btn_left = 0; btn_up = 0; btn_right = 1; btn_down = 1;
        if (e_over != 0) begin
            repeat (3) cyc();
        end else begin
            cyc();
            if (cellv != 2'd0) begin
                e_rej = 1;
                btn_right = 0; btn_down = 0;
                cyc();
                e_rej = 0;
            end else begin
                e_go = 1; e_x = e_cx; e_y = e_cy;
                cyc();
                e_go = 0;
                game_state = gs;
                cyc();
                e_cnt++;
                if (gs != 2'd0) begin
                    e_over = 1; e_win = int'(gs);
                end else if (e_cnt == 49) begin
                    e_over = 1; e_draw = 1;
                end else begin
                    e_color ^= 1;
                end
            end
        end
        btn_right = 0; btn_down = 0; game_state = 2'd0; cell_val = 2'd0;
    endtask

    initial begin
        reset_exp();
        do_reset(2);
        check("lit_reset_cur_x", 32'(cur_x), 3);
        place(2'd0, 2'd0);
        check("lit_first_x", 32'(x), 3);
        check("lit_first_color", 32'(color), 1);
        check("lit_first_count", 32'(move_count), 1);
        place(2'd1, 2'd0);
        check("lit_reject_count", 32'(move_count), 1);
        check("lit_reject_color", 32'(color), 1);
        repeat (5) move(0, 0, 1, 0);
        check("lit_left_sat", 32'(cur_x), 0);
        repeat (10) move(0, 1, 0, 0);
        check("lit_down_sat", 32'(cur_y), 6);
        move(1, 1, 0, 0);
        check("lit_updown", 32'(cur_y), 6);
        move(0, 0, 1, 1);
        move(1, 0, 0, 1);
        place(2'd0, 2'd0);
        check("lit_second_xy", 32'({x, y}), 32'({3'd1, 3'd5}));
        place(2'd0, 2'd2);
        check("lit_win_over", 32'(game_over), 1);
        check("lit_win_winner", 32'(winner), 2);
        check("lit_win_count", 32'(move_count), 3);
        place(2'd0, 2'd0);
        move(0, 0, 1, 0);
        move(1, 0, 0, 0);
        check("lit_over_frozen", 32'(cur_x), 1);
        do_reset(1);
        repeat (49) place(2'd0, 2'd0);
        check("lit_draw", 32'(draw), 1);
        check("lit_draw_count", 32'(move_count), 49);
        check("lit_draw_winner", 32'(winner), 0);
        place(2'd0, 2'd0);
        do_reset(1);
        move(0, 0, 0, 1);
        move(1, 0, 0, 0);
        btn_place = 1;
        cyc();
        btn_place = 0;
        cyc();
        e_go = 1; e_x = 4; e_y = 2;
        resetn = 0;
        cyc();
        reset_exp();
        resetn = 1;
        cyc();
        check("lit_midreset_go", 32'(go), 0);
        check("lit_midreset_cur", 32'({cur_x, cur_y}), 32'({3'd3, 3'd3}));
        move(0, 1, 0, 1);
        cyc();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
